// File: rtl/sum_uart_tx_if.sv
// sum_uart_tx_if: bundles the request/data side and the serial/status side
// of the sum_uart_tx transmitter. The counter stage (or a bench) uses the
// master modport; the transmitter uses the slave modport.
interface sum_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              send;
  logic              tx;
  logic              busy;
  logic              done;
  logic              overrun;

  modport master (
    output data_in,
    output send,
    input  tx,
    input  busy,
    input  done,
    input  overrun
  );

  modport slave (
    input  data_in,
    input  send,
    output tx,
    output busy,
    output done,
    output overrun
  );
endinterface

// File: rtl/sum_uart_tx.sv
// sum_uart_tx: captures the counter value on request and sends it as an
// 8N1 UART frame, LSB first, on a single registered output pin. A one-word
// pending buffer holds a request that arrives during a frame; any further
// request while that buffer is full is dropped and latched in a sticky
// overrun flag. Back-to-back frames follow each other with no idle gap.
// Optional feature: define SUM_UART_TX_PARITY_EN to insert an even-parity
// bit between the last data bit and the stop bit.
module sum_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic          clk,
  input  logic          rst,
  sum_uart_tx_if.slave  bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("sum_uart_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SUM_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t              state_q, state_n;
  logic [DATA_W-1:0]   shift_q, shift_n;
  logic [BIT_W-1:0]    bit_q, bit_n;
  logic [BAUD_W-1:0]   baud_q, baud_n;
  logic [DATA_W-1:0]   pend_q, pend_n;
  logic                pend_v_q, pend_v_n;
  logic                ovr_q, ovr_n;
  logic                tx_q, tx_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                baud_end;
  logic                end_of_stop;
  logic                load;
  logic [DATA_W-1:0]   load_word;
`ifdef SUM_UART_TX_PARITY_EN
  logic                parity_q, parity_n;
`endif

  // Next-state, request handling and next output values for the frame FSM
  always_comb begin
    state_n     = state_q;
    shift_n     = shift_q;
    bit_n       = bit_q;
    pend_n      = pend_q;
    pend_v_n    = pend_v_q;
    ovr_n       = ovr_q;
    done_n      = 1'b0;
    load        = 1'b0;
    load_word   = '0;
    tx_n        = 1'b1;
    baud_end    = (baud_q == BAUD_LAST);
    end_of_stop = (state_q == STOP) && baud_end;
    baud_n      = (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
`ifdef SUM_UART_TX_PARITY_EN
    parity_n    = parity_q;
`endif

    case (state_q)
      IDLE: begin
        bit_n = '0;
        if (bus.send) begin
          load      = 1'b1;
          load_word = bus.data_in;
          state_n   = START;
        end
      end
      START: begin
        if (baud_end) state_n = DATA;
      end
      DATA: begin
        if (baud_end) begin
          shift_n = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_n = '0;
`ifdef SUM_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end
      end
`ifdef SUM_UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) state_n = STOP;
      end
`endif
      STOP: begin
        if (baud_end) begin
          done_n = 1'b1;
          if (pend_v_q) begin
            load      = 1'b1;
            load_word = pend_q;
            pend_v_n  = 1'b0;
            state_n   = START;
          end else if (bus.send) begin
            load      = 1'b1;
            load_word = bus.data_in;
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (state_q != IDLE && bus.send) begin
      if (end_of_stop) begin
        if (pend_v_q) begin
          pend_n   = bus.data_in;
          pend_v_n = 1'b1;
        end
      end else if (!pend_v_q) begin
        pend_n   = bus.data_in;
        pend_v_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end

    if (load) begin
      shift_n = load_word;
`ifdef SUM_UART_TX_PARITY_EN
      parity_n = ^load_word;
`endif
    end

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef SUM_UART_TX_PARITY_EN
      PARITY:  tx_n = parity_n;
`endif
      default: tx_n = 1'b1;
    endcase

    busy_n = (state_n != IDLE) || pend_v_n;
  end

  // State, datapath and registered outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      baud_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      ovr_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SUM_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      shift_q  <= shift_n;
      bit_q    <= bit_n;
      baud_q   <= baud_n;
      pend_q   <= pend_n;
      pend_v_q <= pend_v_n;
      ovr_q    <= ovr_n;
      tx_q     <= tx_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
`ifdef SUM_UART_TX_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// tb_sum_uart_tx: drives directed and random requests into sum_uart_tx and
// compares tx/busy/done/overrun every cycle against a frame-level model that
// tracks which word is on the line, when its frame began, and the pending slot.
module tb_sum_uart_tx;

  localparam int DATA_W = 8;
  localparam int CPB    = 4;
`ifdef SUM_UART_TX_PARITY_EN
  localparam int NBITS  = DATA_W + 3;
`else
  localparam int NBITS  = DATA_W + 2;
`endif
  localparam int FRAME  = NBITS * CPB;

  logic clk = 1'b0;
  logic rst;

  sum_uart_tx_if #(.DATA_W(DATA_W)) bus ();

  sum_uart_tx #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: frame-level view of the line
  logic        m_active;
  int          m_start;
  logic [7:0]  m_word;
  logic        m_pv;
  logic [7:0]  m_pw;
  logic        m_ovr;
  logic        m_done;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic expBit(input logic [7:0] w, input int off);
    int idx;
    idx = off / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= DATA_W) return w[idx-1];
`ifdef SUM_UART_TX_PARITY_EN
    if (idx == DATA_W + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic modelStep(input logic r, input logic s, input logic [7:0] d);
    logic eos;
    cyc++;
    m_done = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_pv     = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      eos = m_active && (cyc - m_start == FRAME);
      if (!m_active) begin
        if (s) begin
          m_active = 1'b1;
          m_start  = cyc;
          m_word   = d;
        end
      end else if (eos) begin
        m_done = 1'b1;
        if (m_pv) begin
          m_start = cyc;
          m_word  = m_pw;
          if (s) m_pw = d;
          else   m_pv = 1'b0;
        end else if (s) begin
          m_start = cyc;
          m_word  = d;
        end else begin
          m_active = 1'b0;
        end
      end else if (s) begin
        if (!m_pv) begin
          m_pv = 1'b1;
          m_pw = d;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [7:0] d);
    logic exp_tx;
    @(negedge clk);
    rst         = r;
    bus.send    = s;
    bus.data_in = d;
    @(posedge clk);
    modelStep(r, s, d);
    #1;
    exp_tx = m_active ? expBit(m_word, cyc - m_start) : 1'b1;
    checkOutput("tx",      32'(bus.tx),      32'(exp_tx));
    checkOutput("busy",    32'(bus.busy),    32'(m_active || m_pv));
    checkOutput("done",    32'(bus.done),    32'(m_done));
    checkOutput("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    rst         = 1'b1;
    bus.send    = 1'b0;
    bus.data_in = '0;
    m_active    = 1'b0;
    m_start     = 0;
    m_word      = '0;
    m_pv        = 1'b0;
    m_pw        = '0;
    m_ovr       = 1'b0;
    m_done      = 1'b0;

    // reset, then a quiet line
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    idleCycles(20);

    // single frame 0xA5
    applyStimulus(1'b0, 1'b1, 8'hA5);
    idleCycles(FRAME + 6);

    // second request at cycle 10 chains with no gap
    applyStimulus(1'b0, 1'b1, 8'h3C);
    idleCycles(9);
    applyStimulus(1'b0, 1'b1, 8'h81);
    idleCycles(2 * FRAME + 6);

    // third request while pending is full is dropped
    applyStimulus(1'b0, 1'b1, 8'h01);
    idleCycles(4);
    applyStimulus(1'b0, 1'b1, 8'h02);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 8'h03);
    idleCycles(2 * FRAME + 6);

    // reset mid-frame, then a clean frame
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF);
    idleCycles(14);
    applyStimulus(1'b1, 1'b0, 8'h00);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1, 8'h55);
    idleCycles(FRAME + 6);

    // sparse random requests with occasional reset
    for (int i = 0; i < 500; i++)
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0), 8'($urandom));

    // dense random requests to exercise pending and overrun
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 400; i++)
      applyStimulus(1'b0, ($urandom_range(0, 2) == 0), 8'($urandom));
    idleCycles(2 * FRAME + 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
